rca_seq_addsub: RTL and testbench
=================================

Name: rca_seq_addsub

Overview:
- Parametrised, multi-cycle ripple-carry adder/subtractor; successor to the fixed 4-bit combinational ripple adder.
- Processes CHUNK bits per clock through a CHUNK-bit full-adder chain, carrying between chunks in a register.
- Valid/ready handshake on input and output; sits in datapaths where area matters more than latency.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits added per clock; 1 <= CHUNK <= WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and mode presented.
- in_ready  output  1  block accepts operands; high only in IDLE.
- a  input  WIDTH  operand A, two's complement or unsigned.
- b  input  WIDTH  operand B.
- sub  input  1  0 = A+B; 1 = A-B.
- out_valid  output  1  result held valid.
- out_ready  input  1  consumer takes result.
- sum  output  WIDTH  result.
- cout  output  1  carry out; for sub, 1 = no borrow.
- ovf  output  1  signed overflow.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; sum=0, cout=0, ovf=0, out_valid=0; in_ready=1 from the following cycle.
  - Chunk index and carry register cleared.
  - Reset has priority over every other event, including mid-RUN and mid-DONE; any in-flight operation is discarded with no output.
- States: IDLE, RUN, DONE. NCHUNK = WIDTH/CHUNK.
- IDLE:
  - On in_valid && in_ready: latch A, latch (B XOR {WIDTH{sub}}), carry = sub, idx = 0, clear sum register, go to RUN.
- RUN:
  - Each cycle, chunk idx (bits idx*CHUNK+CHUNK-1 .. idx*CHUNK) goes through the full-adder chain with the carry register.
  - Result chunk is written into sum; carry register is updated; idx increments.
  - On the last chunk (idx = NCHUNK-1):
    - cout = final carry.
    - ovf = carry into MSB XOR carry out of MSB.
    - Go to DONE.
- DONE:
  - out_valid=1; sum, cout and ovf are stable.
  - On out_ready=1: out_valid drops next cycle and state returns to IDLE.
  - Without out_ready the result is held indefinitely.
- Latency: accept edge to out_valid high = NCHUNK cycles. Throughput: one operation per NCHUNK+2 cycles minimum (accept, NCHUNK run cycles, handoff).
- Input changes while not in IDLE are ignored; in_ready=0 in RUN and DONE.
- sum/cout/ovf are undefined-free: they hold their last values in IDLE until the next completion; intermediate sum bits are visible but out_valid=0 during RUN.
- CHUNK=WIDTH: NCHUNK=1, single RUN cycle.
- Wrap-around: unsigned results are modulo 2^WIDTH; cout flags the wrap.

Optional Feature:
- Macro: RCA_SAT_EN.
- With RCA_SAT_EN defined:
  - When ovf=1 at completion, sum is replaced in DONE by the signed saturation value: 0111..1 if the true result is positive, 1000..0 if negative (sign taken from operand A's MSB).
  - ovf is still reported.
- Without RCA_SAT_EN: sum is the wrapped result; no saturation logic is present.

Decomposition:
- Package rca_pkg:
  - State enum typedef (IDLE, RUN, DONE) with a 2-bit encoding.
  - Mode constants RCA_ADD=1'b0, RCA_SUB=1'b1.
  - Function computing NCHUNK and its index width.
- Sub-module rca_chunk: purely combinational CHUNK-bit ripple chain of full adders.
  - Inputs: a_chunk, b_chunk, cin.
  - Outputs: s_chunk, cout, c_msb_in (carry into the top bit, used for ovf).
  - Instantiated once, time-multiplexed over chunks.

Test Plan (WIDTH=8, CHUNK=2 unless noted):
- a=0x0F, b=0x01, sub=0 -> out_valid exactly 4 cycles after accept; sum=0x10, cout=0, ovf=0.
- a=0xFF, b=0x01, sub=0 -> sum=0x00, cout=1, ovf=0. Then a=0x7F, b=0x01 -> sum=0x80, ovf=1; with RCA_SAT_EN, sum=0x7F, ovf=1.
- a=0x05, b=0x07, sub=1 -> sum=0xFE, cout=0, ovf=0. Then a=0x80, b=0x01, sub=1 -> sum=0x7F, ovf=1; with RCA_SAT_EN, sum=0x80.
- Backpressure: out_ready low for 10 cycles in DONE -> out_valid and sum held, in_ready=0 throughout, and new in_valid is ignored. Then out_ready=1 -> IDLE and in_ready=1 on the next cycle.
- Reset mid-RUN (rst asserted after 2 chunks) -> next cycle state=IDLE, out_valid=0, sum=0, cout=0, ovf=0. A following op 0x03+0x04 gives 0x07.
- WIDTH=16, CHUNK=16: a=0xFFFF, b=0x0001 -> 1-cycle latency, sum=0x0000, cout=1.

Source files
------------

// File: rtl/rca_pkg.sv
// Shared types and helpers for the sequential ripple-carry adder/subtractor.
// Optional saturation on signed overflow is enabled by defining RCA_SAT_EN.
package rca_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } rca_state_t;

    localparam logic RCA_ADD = 1'b0;
    localparam logic RCA_SUB = 1'b1;

    function automatic int rca_nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    function automatic int rca_idx_w(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/rca_chunk.sv
// Combinational CHUNK-bit ripple chain of full adders.
// Also exposes the carry into the top bit for overflow detection.
module rca_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a_chunk,
    input  logic [CHUNK-1:0] b_chunk,
    input  logic             cin,
    output logic [CHUNK-1:0] s_chunk,
    output logic             cout,
    output logic             c_msb_in
);

    logic [CHUNK:0] c;

    always_comb begin
        c       = '0;
        s_chunk = '0;
        c[0]    = cin;
        for (int i = 0; i < CHUNK; i++) begin
            s_chunk[i] = a_chunk[i] ^ b_chunk[i] ^ c[i];
            c[i+1]     = (a_chunk[i] & b_chunk[i]) |
                         (c[i] & (a_chunk[i] ^ b_chunk[i]));
        end
    end

    assign cout     = c[CHUNK];
    assign c_msb_in = c[CHUNK-1];

endmodule

// File: rtl/rca_seq_addsub.sv
// Multi-cycle ripple-carry add/sub, CHUNK bits per clock, valid/ready on both sides.
// Define RCA_SAT_EN to saturate the result on signed overflow.
module rca_seq_addsub
    import rca_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NCH = rca_nchunk(WIDTH, CHUNK);
    localparam int IW  = rca_idx_w(NCH);

    rca_state_t state_q, state_d;

    logic [WIDTH-1:0] a_q, b_q, sum_q, sum_d, sum_fin;
    logic [IW-1:0]    idx_q;
    logic             carry_q, cout_q, ovf_q;
    logic [CHUNK-1:0] a_ch, b_ch, s_ch;
    logic             co, cm, last;

    assign a_ch = a_q[idx_q*CHUNK +: CHUNK];
    assign b_ch = b_q[idx_q*CHUNK +: CHUNK];
    assign last = (idx_q == IW'(NCH - 1));

    rca_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a_chunk  (a_ch),
        .b_chunk  (b_ch),
        .cin      (carry_q),
        .s_chunk  (s_ch),
        .cout     (co),
        .c_msb_in (cm)
    );

    always_comb begin
        sum_d = sum_q;
        sum_d[idx_q*CHUNK +: CHUNK] = s_ch;
`ifdef RCA_SAT_EN
        // Overflow sign follows A: positive A can only overflow upward.
        if (co ^ cm)
            sum_fin = {a_q[WIDTH-1], {(WIDTH-1){~a_q[WIDTH-1]}}};
        else
            sum_fin = sum_d;
`else
        sum_fin = sum_d;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid) state_d = RUN;
            RUN:     if (last) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (state_q == IDLE && in_valid) begin
                a_q     <= a;
                b_q     <= b ^ {WIDTH{sub}};
                carry_q <= (sub == RCA_SUB);
                idx_q   <= '0;
                sum_q   <= '0;
            end else if (state_q == RUN) begin
                sum_q   <= last ? sum_fin : sum_d;
                carry_q <= co;
                idx_q   <= idx_q + IW'(1);
                if (last) begin
                    cout_q <= co;
                    ovf_q  <= co ^ cm;
                end
            end
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_rca_seq_addsub.sv
// Scoreboard bench: directed vectors for WIDTH=8/CHUNK=2 and WIDTH=16/CHUNK=16.
// Expected saturated values apply when RCA_SAT_EN is defined.
module tb_rca_seq_addsub;

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        o;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       in_valid1 = 1'b0, in_ready1, sub1 = 1'b0;
    logic [7:0] a1 = '0, b1 = '0, sum1;
    logic       out_valid1, out_ready1 = 1'b1, cout1, ovf1;

    logic        in_valid2 = 1'b0, in_ready2, sub2 = 1'b0;
    logic [15:0] a2 = '0, b2 = '0, sum2;
    logic        out_valid2, out_ready2 = 1'b1, cout2, ovf2;

    exp_t q1[$];
    exp_t q2[$];
    exp_t e1, e2;

    int nvec = 0;
    int nmis = 0;

    always #5 clk = ~clk;

    rca_seq_addsub #(.WIDTH(8), .CHUNK(2)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .sub(sub1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .cout(cout1), .ovf(ovf1)
    );

    rca_seq_addsub #(.WIDTH(16), .CHUNK(16)) dut2 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a2), .b(b2), .sub(sub2),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .sum(sum2), .cout(cout2), .ovf(ovf2)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        nvec++;
        if (act !== req) begin
            nmis++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (out_valid1 && out_ready1) begin
            if (q1.size() == 0) begin
                chk("dut1_unexpected_output", 32'(sum1), 32'hFFFF_FFFF);
            end else begin
                e1 = q1.pop_front();
                chk("dut1_sum", 32'(sum1), 32'(e1.s[7:0]));
                chk("dut1_cout", 32'(cout1), 32'(e1.c));
                chk("dut1_ovf", 32'(ovf1), 32'(e1.o));
            end
        end
    end

    always @(negedge clk) begin
        if (out_valid2 && out_ready2) begin
            if (q2.size() == 0) begin
                chk("dut2_unexpected_output", 32'(sum2), 32'hFFFF_FFFF);
            end else begin
                e2 = q2.pop_front();
                chk("dut2_sum", 32'(sum2), 32'(e2.s));
                chk("dut2_cout", 32'(cout2), 32'(e2.c));
                chk("dut2_ovf", 32'(ovf2), 32'(e2.o));
            end
        end
    end

    // Called #1 after a posedge with dut1 idle.
    task automatic op1(input logic [7:0] av, input logic [7:0] bv,
                       input logic sv, input logic [7:0] es,
                       input logic ec, input logic eo, input bit hold);
        int cyc;
        a1 = av; b1 = bv; sub1 = sv; in_valid1 = 1'b1;
        q1.push_back('{s: {8'h00, es}, c: ec, o: eo});
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        cyc = 0;
        while (!out_valid1 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("dut1_latency", 32'(cyc), 32'd4);
        if (!hold) begin
            @(posedge clk); #1;
            chk("dut1_in_ready_after", 32'(in_ready1), 32'd1);
        end
    endtask

    task automatic op2(input logic [15:0] av, input logic [15:0] bv,
                       input logic sv, input logic [15:0] es,
                       input logic ec, input logic eo);
        int cyc;
        a2 = av; b2 = bv; sub2 = sv; in_valid2 = 1'b1;
        q2.push_back('{s: es, c: ec, o: eo});
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        cyc = 0;
        while (!out_valid2 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("dut2_latency", 32'(cyc), 32'd1);
        @(posedge clk); #1;
        chk("dut2_in_ready_after", 32'(in_ready2), 32'd1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_sum", 32'(sum1), 32'h0);
        chk("rst_cout", 32'(cout1), 32'h0);
        chk("rst_ovf", 32'(ovf1), 32'h0);
        chk("rst_out_valid", 32'(out_valid1), 32'h0);
        chk("rst_in_ready", 32'(in_ready1), 32'h1);

        op1(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0);
        op1(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
`ifdef RCA_SAT_EN
        op1(8'h7F, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0);
`else
        op1(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
`endif
        op1(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0);
`ifdef RCA_SAT_EN
        op1(8'h80, 8'h01, 1'b1, 8'h80, 1'b1, 1'b1, 1'b0);
`else
        op1(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0);
`endif

        // Reset after two chunks of 0x55+0x22; no result may emerge.
        a1 = 8'h55; b1 = 8'h22; sub1 = 1'b0; in_valid1 = 1'b1;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrun_rst_out_valid", 32'(out_valid1), 32'h0);
        chk("midrun_rst_in_ready", 32'(in_ready1), 32'h1);
        chk("midrun_rst_sum", 32'(sum1), 32'h0);
        chk("midrun_rst_cout", 32'(cout1), 32'h0);
        chk("midrun_rst_ovf", 32'(ovf1), 32'h0);

        op1(8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0, 1'b0);
`ifdef RCA_SAT_EN
        op1(8'hAA, 8'h55, 1'b1, 8'h80, 1'b1, 1'b1, 1'b0);
`else
        op1(8'hAA, 8'h55, 1'b1, 8'h55, 1'b1, 1'b1, 1'b0);
`endif

        // Backpressure: hold result for 10 cycles while new requests knock.
        out_ready1 = 1'b0;
        op1(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            a1 = 8'(i); b1 = 8'hA0; sub1 = 1'b1; in_valid1 = 1'b1;
            @(posedge clk); #1;
            chk("bp_out_valid", 32'(out_valid1), 32'h1);
            chk("bp_sum_held", 32'(sum1), 32'h46);
            chk("bp_in_ready", 32'(in_ready1), 32'h0);
        end
        in_valid1 = 1'b0;
        out_ready1 = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_in_ready", 32'(in_ready1), 32'h1);
        chk("bp_release_out_valid", 32'(out_valid1), 32'h0);

        op2(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
`ifdef RCA_SAT_EN
        op2(16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
`else
        op2(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
`endif
        op2(16'h1234, 16'h1235, 1'b1, 16'hFFFF, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        chk("dut1_queue_drained", 32'(q1.size()), 32'd0);
        chk("dut2_queue_drained", 32'(q2.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
